// File: rtl/dir_rom_scan_ctrl.sv
// ---------------------------------------------------------------------------
// dir_rom_scan_ctrl
//
// Purpose
//   Sequencer for the SIFT descriptor direction ROMs. A ROM maps an 8-bit
//   sample position {row[3:0], col[3:0]} to a 5-bit direction bin. When the
//   keypoint scheduler pulses start, this block walks one whole 16x16 sample
//   window through the ROM port, one address per clock. Each lookup is
//   registered and streamed as {addr, bin} to the descriptor histogram
//   accumulator over a valid/ready interface.
//
// Build option
//   ORIENT_ROT_EN  When defined, every bin is rotated by the keypoint's main
//                  orientation: bin = (rom_spo + ori_q) mod 2**BIN_W. ori_q is
//                  latched from ori_in when start is accepted.
//                  When undefined, bin = rom_spo, ori_in is ignored and ori_q
//                  is tied to zero.
//
// Parameters
//   ADDR_W  ROM address width; a scan covers 0 .. 2**ADDR_W-1
//   BIN_W   direction-bin width; bin arithmetic is mod 2**BIN_W
//
// Ports
//   clk        in   1       system clock, rising edge
//   rst        in   1       synchronous, active-high reset
//   start      in   1       begin a window scan; only looked at in IDLE
//   ori_in     in   BIN_W   keypoint main-orientation bin
//   busy       out  1       high whenever the FSM is not in IDLE
//   rom_a      out  ADDR_W  ROM address, straight from the scan counter
//   rom_spo    in   BIN_W   ROM data, combinational from rom_a
//   out_valid  out  1       output beat valid
//   out_ready  in   1       downstream ready
//   out_addr   out  ADDR_W  address of the current beat
//   out_bin    out  BIN_W   direction bin of the current beat
//   out_last   out  1       current beat is address 2**ADDR_W-1
//   done       out  1       registered one-cycle pulse after the last beat
//   dbg_state  out  2       current FSM state (IDLE=0 SCAN=1 DRAIN=2 DONE=3)
//
// Output handshake
//   A beat transfers on a rising edge where out_valid & out_ready are both 1.
//   Once out_valid is raised, out_addr/out_bin/out_last do not change and
//   out_valid does not drop until that beat has transferred. out_valid does
//   not depend combinationally on out_ready.
// ---------------------------------------------------------------------------
module dir_rom_scan_ctrl #(
  parameter int ADDR_W = 8,
  parameter int BIN_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BIN_W-1:0]  ori_in,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_a,
  input  logic [BIN_W-1:0]  rom_spo,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [BIN_W-1:0]  out_bin,
  output logic              out_last,
  output logic              done,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [BIN_W-1:0]  ori_q;
  logic [BIN_W-1:0]  bin_f;
  logic              start_acc;
  logic              load;
  logic              beat_taken;
  logic              cnt_at_last;

  // -------------------------------------------------------------------------
  // Orientation rotation (build option)
  // -------------------------------------------------------------------------
`ifdef ORIENT_ROT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ori_q <= '0;
    end else if (start_acc) begin
      ori_q <= ori_in;
    end
  end

  // BIN_W-bit add: the carry out is dropped, giving the wrap mod 2**BIN_W.
  assign bin_f = rom_spo + ori_q;
`else
  logic unused_ori;

  assign ori_q      = '0;
  assign bin_f      = rom_spo;
  assign unused_ori = &{1'b0, ori_in, ori_q};
`endif

  // -------------------------------------------------------------------------
  // Control terms
  // -------------------------------------------------------------------------
  assign start_acc   = (state == S_IDLE) && start;
  assign beat_taken  = out_valid && out_ready;
  assign cnt_at_last = (cnt == LAST_ADDR);

  // A new lookup may enter the output register when it is empty or when the
  // beat sitting in it is leaving on this same edge. This keeps 1 beat/clk
  // under continuous ready while never overwriting an unaccepted beat.
  assign load = (state == S_SCAN) && (!out_valid || out_ready);

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        // The final address has been loaded; only its handshake remains.
        if (load && cnt_at_last) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (beat_taken) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Scan counter. Holds outside SCAN; the load at the last address wraps it
  // back to zero, so it already reads 0 when the next scan starts.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (start_acc) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= cnt + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Output beat register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_bin   <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_addr  <= cnt;
      out_bin   <= bin_f;
      out_last  <= cnt_at_last;
    end else if (beat_taken) begin
      // Beat left and nothing replaces it (DRAIN, or SCAN cannot happen here
      // because a taken beat always permits a load in SCAN).
      out_valid <= 1'b0;
    end
  end

  // done is registered: it rises on the edge that enters DONE and falls on the
  // edge that leaves it, giving exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
    end else begin
      done <= (state == S_DRAIN) && beat_taken;
    end
  end

  // -------------------------------------------------------------------------
  // Combinational outputs
  // -------------------------------------------------------------------------
  assign rom_a     = cnt;
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule
